// File: rtl/sobel_pkg.sv
// sobel_pkg: output modes, pipeline latency and gradient width helper for sobel_edge_filter.
package sobel_pkg;
  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_HORZ = 2'd1,
    MODE_VERT = 2'd2,
    MODE_MAG  = 2'd3
  } mode_t;
  localparam int SOBEL_LAT = 3;
  function automatic int grad_w(input int data_w);
    return data_w + 3;
  endfunction
endpackage

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: clock-enabled LINE_W-deep shift RAM; tap is the sample written LINE_W accepts ago.
module sobel_line_buffer #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] tap
);
  localparam int AW = LINE_W > 1 ? $clog2(LINE_W) : 1;
  logic [DATA_W-1:0] mem [LINE_W];
  logic [AW-1:0] ptr;
  assign tap = mem[ptr];
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (clken) ptr <= (ptr == AW'(LINE_W - 1)) ? '0 : ptr + 1'b1;
  end
  // RAM contents survive reset; only the pointer realigns to the new frame
  always_ff @(posedge clk) begin
    if (clken && !rst) mem[ptr] <= din;
  end
endmodule

// File: rtl/sobel_edge_filter.sv
// sobel_edge_filter: 3x3 Sobel / gray filter on a pixel stream, result replicated on R/G/B.
// Define SOBEL_THRESH_EN to binarise the edge modes against iThresh.
module sobel_edge_filter
  import sobel_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int CNT_W  = 11
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iDVAL,
  input  logic [CNT_W-1:0]  iX_Cont,
  input  logic [CNT_W-1:0]  iY_Cont,
  input  logic [1:0]        iMode,
  input  logic [DATA_W-1:0] iThresh,
  output logic [DATA_W-1:0] oRed,
  output logic [DATA_W-1:0] oGreen,
  output logic [DATA_W-1:0] oBlue,
  output logic              oDVAL
);
  localparam int GW = grad_w(DATA_W);
  localparam logic [GW-1:0] MAXV = GW'((1 << DATA_W) - 1);
  logic [DATA_W-1:0] row1, row2, c1, sat, res;
  logic [2:0][DATA_W-1:0] top, mid, bot;
  logic [SOBEL_LAT-1:0] vld;
  logic mask0, mask1, mask2;
  mode_t mode_q, mode_in, mode1;
  logic signed [GW-1:0] gx, gy, gx1, gy1;
  logic [GW-1:0] ax, ay, val2;

  sobel_line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) lb1 (
    .clk(iCLK), .rst(iRST), .clken(iDVAL), .din(iDATA), .tap(row1)
  );
  sobel_line_buffer #(.DATA_W(DATA_W), .LINE_W(LINE_W)) lb2 (
    .clk(iCLK), .rst(iRST), .clken(iDVAL), .din(row1), .tap(row2)
  );

  function automatic logic signed [GW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({{(GW - DATA_W){1'b0}}, p});
  endfunction

  // Mode changes only at the first pixel of a frame so a frame is never torn
  assign mode_in = (iX_Cont == '0 && iY_Cont == '0) ? mode_t'(iMode) : mode_q;
  assign gx = (ext(top[2]) + (ext(mid[2]) <<< 1) + ext(bot[2]))
            - (ext(top[0]) + (ext(mid[0]) <<< 1) + ext(bot[0]));
  assign gy = (ext(bot[0]) + (ext(bot[1]) <<< 1) + ext(bot[2]))
            - (ext(top[0]) + (ext(top[1]) <<< 1) + ext(top[2]));
  assign ax = gx1[GW-1] ? -gx1 : gx1;
  assign ay = gy1[GW-1] ? -gy1 : gy1;
  assign sat = (val2 > MAXV) ? '1 : val2[DATA_W-1:0];
`ifdef SOBEL_THRESH_EN
  logic edge2;
  assign res = mask2 ? '0 : !edge2 ? sat : (sat >= iThresh) ? '1 : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^iThresh;
  assign res = mask2 ? '0 : sat;
`endif

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      {top, mid, bot} <= '0;
      vld <= '0;
      mode_q <= MODE_GRAY;
      mode1 <= MODE_GRAY;
      {mask0, mask1, mask2} <= '0;
      gx1 <= '0;
      gy1 <= '0;
      c1 <= '0;
      val2 <= '0;
`ifdef SOBEL_THRESH_EN
      edge2 <= 1'b0;
`endif
      oRed <= '0;
      oGreen <= '0;
      oBlue <= '0;
      oDVAL <= 1'b0;
    end else begin
      vld <= {vld[SOBEL_LAT-2:0], iDVAL};
      if (iDVAL) begin
        top <= {row2, top[2:1]};
        mid <= {row1, mid[2:1]};
        bot <= {iDATA, bot[2:1]};
        mask0 <= iX_Cont < CNT_W'(2) || iY_Cont < CNT_W'(2);
        mode_q <= mode_in;
      end
      gx1 <= gx;
      gy1 <= gy;
      c1 <= mid[1];
      mask1 <= mask0;
      mode1 <= mode_q;
      val2 <= (mode1 == MODE_GRAY) ? GW'(c1) : (mode1 == MODE_HORZ) ? ay :
              (mode1 == MODE_VERT) ? ax : ax + ay;
      mask2 <= mask1;
`ifdef SOBEL_THRESH_EN
      edge2 <= mode1 != MODE_GRAY;
`endif
      oRed <= res;
      oGreen <= res;
      oBlue <= res;
      oDVAL <= vld[SOBEL_LAT-1];
    end
  end
endmodule
